// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer control slice.
// The BEST_TIME_EN macro lives in reaction_ctrl.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RWAIT   = 3'd2,
    RAND    = 3'd3,
    GO      = 3'd4,
    DONE    = 3'd5,
    EARLY   = 3'd6,
    TIMEOUT = 3'd7
  } state_e;

  localparam int MS_W_DEF   = 14;
  localparam int MAX_MS_DEF = 9999;

  // Galois form of x^16+x^14+x^13+x^11+1 (right shift)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/reaction_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the random delay source.
// Advances every clock; SEED must be nonzero.
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= SEED;
    end else begin
      value <= {1'b0, value[15:1]}
             ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction timer trial sequencer: arm, random wait, GO, measure.
// Define BEST_TIME_EN to track the best valid time in best_ms.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int          MS_W      = MS_W_DEF,
  parameter int          MAX_MS    = MAX_MS_DEF,
  parameter int          RAND_W    = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_1ms,
  input  logic            start_btn,
  input  logic            stop_btn,
  input  logic            rwait_done,
  output logic            rwait_clr,
  output logic            start_rwait,
  output logic            led_go,
  output logic [MS_W-1:0] react_ms,
  output logic            result_valid,
  output logic            early_flag,
  output logic            timeout_flag,
  output logic [MS_W-1:0] best_ms
);

  localparam logic [MS_W-1:0] MAX_V  = MS_W'(MAX_MS);
  localparam logic [MS_W-1:0] LAST_V = MS_W'(MAX_MS - 1);

  state_e              state;
  logic [RAND_W-1:0]   rand_cnt;
  logic [15:0]         lfsr;
  logic                lfsr_unused;

  assign lfsr_unused = ^lfsr[15:RAND_W];

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rand_cnt     <= '0;
      rwait_clr    <= 1'b0;
      start_rwait  <= 1'b0;
      led_go       <= 1'b0;
      react_ms     <= '0;
      result_valid <= 1'b0;
      early_flag   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      rwait_clr <= 1'b0;
      unique case (state)
        IDLE, DONE, EARLY, TIMEOUT: begin
          if (start_btn) begin
            state        <= ARM;
            rwait_clr    <= 1'b1;
            start_rwait  <= 1'b0;
            led_go       <= 1'b0;
            react_ms     <= '0;
            result_valid <= 1'b0;
            early_flag   <= 1'b0;
            timeout_flag <= 1'b0;
          end
        end
        ARM: begin
          state       <= RWAIT;
          start_rwait <= 1'b1;
        end
        RWAIT: begin
          if (stop_btn) begin
            state       <= EARLY;
            early_flag  <= 1'b1;
            start_rwait <= 1'b0;
          end else if (rwait_done) begin
            state       <= RAND;
            rand_cnt    <= lfsr[RAND_W-1:0];
            start_rwait <= 1'b0;
          end
        end
        RAND: begin
          if (stop_btn) begin
            state      <= EARLY;
            early_flag <= 1'b1;
          end else if (rand_cnt == '0) begin
            state  <= GO;
            led_go <= 1'b1;
          end else if (tick_1ms) begin
            rand_cnt <= rand_cnt - 1'b1;
          end
        end
        GO: begin
          // a tick coinciding with stop is deliberately not counted
          if (stop_btn) begin
            state        <= DONE;
            result_valid <= 1'b1;
            led_go       <= 1'b0;
          end else if (tick_1ms) begin
            if (react_ms == LAST_V) begin
              state        <= TIMEOUT;
              react_ms     <= MAX_V;
              timeout_flag <= 1'b1;
              led_go       <= 1'b0;
            end else begin
              react_ms <= react_ms + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef BEST_TIME_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_ms <= '1;
    end else if (state == GO && stop_btn
                 && react_ms < best_ms) begin
      best_ms <= react_ms;
    end
  end
`else
  assign best_ms = '0;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl: one default-limit and one short-limit instance.
// Expected best_ms follows BEST_TIME_EN.
module tb_reaction_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_1ms = 1'b0;
  logic start_btn = 1'b0;
  logic stop_btn = 1'b0;
  logic rwait_done = 1'b0;

  logic        a_rwait_clr, a_start_rwait, a_led_go;
  logic [13:0] a_react_ms, a_best_ms;
  logic        a_result_valid, a_early_flag, a_timeout_flag;

  logic        b_rwait_clr, b_start_rwait, b_led_go;
  logic [13:0] b_react_ms, b_best_ms;
  logic        b_result_valid, b_early_flag, b_timeout_flag;

  logic [15:0] m_lfsr;
  logic [13:0] best_model;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  reaction_ctrl #(.MS_W(14), .MAX_MS(9999), .RAND_W(3)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .tick_1ms     (tick_1ms),
    .start_btn    (start_btn),
    .stop_btn     (stop_btn),
    .rwait_done   (rwait_done),
    .rwait_clr    (a_rwait_clr),
    .start_rwait  (a_start_rwait),
    .led_go       (a_led_go),
    .react_ms     (a_react_ms),
    .result_valid (a_result_valid),
    .early_flag   (a_early_flag),
    .timeout_flag (a_timeout_flag),
    .best_ms      (a_best_ms)
  );

  reaction_ctrl #(.MS_W(14), .MAX_MS(10), .RAND_W(3)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .tick_1ms     (tick_1ms),
    .start_btn    (start_btn),
    .stop_btn     (stop_btn),
    .rwait_done   (rwait_done),
    .rwait_clr    (b_rwait_clr),
    .start_rwait  (b_start_rwait),
    .led_go       (b_led_go),
    .react_ms     (b_react_ms),
    .result_valid (b_result_valid),
    .early_flag   (b_early_flag),
    .timeout_flag (b_timeout_flag),
    .best_ms      (b_best_ms)
  );

  // reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= {1'b0, m_lfsr[15:1]}
                 ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_best();
`ifdef BEST_TIME_EN
    return {18'd0, best_model};
`else
    return 32'd0;
`endif
  endfunction

  // called in RWAIT; fires rwait_done when the loaded value will be v
  task automatic wait_rand(input int v);
    int n;
    n = 0;
    while (m_lfsr[2:0] != v[2:0] && n < 300) begin
      step();
      n++;
    end
    chk("rand_search", {31'd0, n < 300}, 1);
    rwait_done = 1'b1;
    step();
    rwait_done = 1'b0;
  endtask

  task automatic run_trial(input int ms);
    int n;
    start_btn = 1'b1; step(); start_btn = 1'b0;
    rwait_done = 1'b1; step(); step();
    rwait_done = 1'b0;
    tick_1ms = 1'b1;
    n = 0;
    while (!a_led_go && n < 50) begin
      step();
      n++;
    end
    chk("trial_go", {31'd0, a_led_go}, 1);
    repeat (ms) step();
    tick_1ms = 1'b0;
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    chk("trial_ms", a_react_ms, ms);
    chk("trial_valid", {31'd0, a_result_valid}, 1);
    if (ms[13:0] < best_model) best_model = ms[13:0];
    chk("trial_best", a_best_ms, exp_best());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    best_model = '1;
    repeat (3) step();
    chk("rst_clr", {31'd0, a_rwait_clr}, 0);
    chk("rst_rwait", {31'd0, a_start_rwait}, 0);
    chk("rst_led", {31'd0, a_led_go}, 0);
    chk("rst_ms", a_react_ms, 0);
    chk("rst_flags", {29'd0, a_result_valid,
        a_early_flag, a_timeout_flag}, 0);
    chk("rst_best", a_best_ms, exp_best());
    reset = 1'b1;
    step();

    // trial 1: extra delay 3, 250 ms
    start_btn = 1'b1; step(); start_btn = 1'b0;
    chk("arm_clr", {31'd0, a_rwait_clr}, 1);
    chk("arm_rwait", {31'd0, a_start_rwait}, 0);
    step();
    chk("rw_clr", {31'd0, a_rwait_clr}, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_start_rwait) cnt++;
      step();
    end
    chk("rw_high", cnt, 20);
    wait_rand(3);
    chk("rand_rwait", {31'd0, a_start_rwait}, 0);
    for (int i = 0; i < 3; i++) begin
      tick_1ms = 1'b1; step(); tick_1ms = 1'b0;
      chk("rand_led", {31'd0, a_led_go}, 0);
      step();
    end
    chk("go_led", {31'd0, a_led_go}, 1);
    chk("go_ms0", a_react_ms, 0);
    tick_1ms = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      step();
      if (i == 9) chk("b_ms9", b_react_ms, 9);
      if (i == 10) begin
        chk("b_ms10", b_react_ms, 10);
        chk("b_tmo", {31'd0, b_timeout_flag}, 1);
        chk("b_led", {31'd0, b_led_go}, 0);
      end
      if (i == 11) chk("b_nowrap", b_react_ms, 10);
    end
    tick_1ms = 1'b0;
    chk("go_ms250", a_react_ms, 250);
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    chk("done_ms", a_react_ms, 250);
    chk("done_valid", {31'd0, a_result_valid}, 1);
    chk("done_flags", {30'd0, a_early_flag,
        a_timeout_flag}, 0);
    chk("done_led", {31'd0, a_led_go}, 0);
    best_model = 14'd250;
    chk("done_best", a_best_ms, exp_best());
    chk("b_tmo_hold", b_react_ms, 10);
    chk("b_tmo_valid", {31'd0, b_result_valid}, 0);

    // restart clears flags
    start_btn = 1'b1; step(); start_btn = 1'b0;
    chk("re_b_tmo", {31'd0, b_timeout_flag}, 0);
    chk("re_b_ms", b_react_ms, 0);
    chk("re_a_valid", {31'd0, a_result_valid}, 0);
    chk("re_clr", {31'd0, a_rwait_clr}, 1);

    // early in RWAIT
    step(); step(); step();
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    chk("erw_flag", {31'd0, a_early_flag}, 1);
    chk("erw_rwait", {31'd0, a_start_rwait}, 0);
    chk("erw_valid", {31'd0, a_result_valid}, 0);
    tick_1ms = 1'b1; repeat (10) step(); tick_1ms = 1'b0;
    chk("erw_led", {31'd0, a_led_go}, 0);

    // early in RAND with rand_cnt 5
    start_btn = 1'b1; step(); start_btn = 1'b0;
    step();
    wait_rand(5);
    tick_1ms = 1'b1; step(); tick_1ms = 1'b0;
    chk("erd_led", {31'd0, a_led_go}, 0);
    chk("erd_pre", {31'd0, a_early_flag}, 0);
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    chk("erd_flag", {31'd0, a_early_flag}, 1);

    // stop coincident with rwait_done
    start_btn = 1'b1; step(); start_btn = 1'b0;
    step(); step();
    stop_btn = 1'b1; rwait_done = 1'b1; step();
    stop_btn = 1'b0; rwait_done = 1'b0;
    chk("eco_flag", {31'd0, a_early_flag}, 1);
    chk("eco_rwait", {31'd0, a_start_rwait}, 0);
    tick_1ms = 1'b1; repeat (12) step(); tick_1ms = 1'b0;
    chk("eco_led", {31'd0, a_led_go}, 0);

    // zero delay, start mid-GO, stop with tick at 7
    start_btn = 1'b1; step(); start_btn = 1'b0;
    step();
    wait_rand(0);
    chk("z_led0", {31'd0, a_led_go}, 0);
    step();
    chk("z_led1", {31'd0, a_led_go}, 1);
    tick_1ms = 1'b1; repeat (7) step(); tick_1ms = 1'b0;
    start_btn = 1'b1; step(); start_btn = 1'b0;
    chk("mid_led", {31'd0, a_led_go}, 1);
    chk("mid_clr", {31'd0, a_rwait_clr}, 0);
    chk("mid_ms", a_react_ms, 7);
    tick_1ms = 1'b1; stop_btn = 1'b1; step();
    tick_1ms = 1'b0; stop_btn = 1'b0;
    chk("st_ms", a_react_ms, 7);
    chk("st_valid", {31'd0, a_result_valid}, 1);
    chk("st_led", {31'd0, a_led_go}, 0);
    best_model = 14'd7;
    chk("st_best", a_best_ms, exp_best());

    // asynchronous reset while in GO
    start_btn = 1'b1; step(); start_btn = 1'b0;
    rwait_done = 1'b1; step(); step(); rwait_done = 1'b0;
    tick_1ms = 1'b1;
    cnt = 0;
    while (!a_led_go && cnt < 50) begin
      step();
      cnt++;
    end
    repeat (4) step();
    tick_1ms = 1'b0;
    chk("ar_go", {31'd0, a_led_go}, 1);
    reset = 1'b0;
    #1;
    best_model = '1;
    chk("ar_led", {31'd0, a_led_go}, 0);
    chk("ar_ms", a_react_ms, 0);
    chk("ar_valid", {31'd0, a_result_valid}, 0);
    chk("ar_best", a_best_ms, exp_best());
    reset = 1'b1;
    step();

    // best-time sequence: 300, 180, early, 220
    run_trial(300);
    run_trial(180);
    start_btn = 1'b1; step(); start_btn = 1'b0;
    step();
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    chk("bs_early", {31'd0, a_early_flag}, 1);
    chk("bs_ebest", a_best_ms, exp_best());
    run_trial(220);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
